// File: rtl/ntt_writeback_unit.sv
// Write-side packer for an NTT core: pairs butterfly results into 60-bit words for the ping-pong RAMs.
// Optional macro NTT_WB_OUTREG_EN adds one register stage on the write ports (stage_done follows it).
module ntt_writeback_unit #(
    parameter int DATA_WIDTH     = 30,
    parameter int ADDR_WIDTH     = 9,
    parameter int PIPE_LATENCY   = 6,
    parameter int LOG_CORE_COUNT = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      read_valid,
    input  logic [ADDR_WIDTH-1:0]     read_address,
    input  logic [DATA_WIDTH-1:0]     r1,
    input  logic [DATA_WIDTH-1:0]     r2,
    input  logic [DATA_WIDTH-1:0]     r3,
    input  logic [DATA_WIDTH-1:0]     r4,
    output logic                      upper_write_enable,
    output logic [ADDR_WIDTH-1:0]     upper_write_address,
    output logic [2*DATA_WIDTH-1:0]   upper_data_input,
    output logic                      lower_write_enable,
    output logic [ADDR_WIDTH-1:0]     lower_write_address,
    output logic [2*DATA_WIDTH-1:0]   lower_data_input,
    output logic                      write_select,
    output logic                      busy,
    output logic                      stage_done,
    output logic                      pair_error
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting reads until one full stage has been issued
    // FLUSH | draining delayed results and the last pending B write
    // DONE  | stage_done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int IW = $clog2(PIPE_LATENCY + 3);
    localparam logic [AW:0]   N_WORDS    = (AW+1)'(1) << AW;
    localparam logic [AW-1:0] HALF       = AW'(1) << (AW - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(PIPE_LATENCY + 1);

    if (PIPE_LATENCY < 1 || ADDR_WIDTH < 2 || LOG_CORE_COUNT < 0) begin : g_param_check
        $error("ntt_writeback_unit: illegal parameter set");
    end

    state_t                state;
    logic [PIPE_LATENCY-1:0] dly_v;
    logic [AW-1:0]         dly_a [PIPE_LATENCY];
    logic [AW:0]           rd_cnt, wr_cnt;
    logic [IW-1:0]         idle_cnt;
    logic                  hold_v;
    logic [AW-2:0]         hold_a;
    logic [DW-1:0]         hold_r1, hold_r2, hold_r3, hold_r4;
    logic                  pend_v;
    logic [AW-1:0]         pend_a;
    logic [2*DW-1:0]       pend_u, pend_l;
    logic                  write_select_r, busy_r, stage_done_r, pair_error_r;

    logic                  d_v, accept, pair_ok, pair_err, w_en;
    logic [AW-1:0]         d_a, w_addr;
    logic [2*DW-1:0]       w_u, w_l;

    assign d_v      = dly_v[PIPE_LATENCY-1];
    assign d_a      = dly_a[PIPE_LATENCY-1];
    assign accept   = read_valid && (state == RUN);
    assign pair_ok  = d_v && d_a[0] && hold_v && (hold_a == d_a[AW-1:1]);
    assign pair_err = d_v && (d_a[0] ? !pair_ok : hold_v);

    // A writes and pending B writes can never coincide: an A write needs an even result the cycle before.
    always_comb begin
        w_en   = 1'b0;
        w_addr = '0;
        w_u    = '0;
        w_l    = '0;
        if (pair_ok) begin
            w_en   = 1'b1;
            w_addr = {1'b0, d_a[AW-1:1]};
            w_u    = {r1, hold_r1};
            w_l    = {r3, hold_r3};
        end else if (pend_v) begin
            w_en   = 1'b1;
            w_addr = pend_a;
            w_u    = pend_u;
            w_l    = pend_l;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            dly_v          <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) dly_a[i] <= '0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            idle_cnt       <= '0;
            hold_v         <= 1'b0;
            hold_a         <= '0;
            hold_r1        <= '0;
            hold_r2        <= '0;
            hold_r3        <= '0;
            hold_r4        <= '0;
            pend_v         <= 1'b0;
            pend_a         <= '0;
            pend_u         <= '0;
            pend_l         <= '0;
            write_select_r <= 1'b0;
            busy_r         <= 1'b0;
            stage_done_r   <= 1'b0;
            pair_error_r   <= 1'b0;
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                dly_v[i] <= dly_v[i-1];
                dly_a[i] <= dly_a[i-1];
            end
            dly_v[0] <= accept;
            dly_a[0] <= read_address;

            // An even result always lands in hold, even when it overwrites a stale one (flagged below).
            if (d_v && !d_a[0]) begin
                hold_v  <= 1'b1;
                hold_a  <= d_a[AW-1:1];
                hold_r1 <= r1;
                hold_r2 <= r2;
                hold_r3 <= r3;
                hold_r4 <= r4;
            end else if (pair_ok) begin
                hold_v <= 1'b0;
            end

            pend_v <= pair_ok;
            if (pair_ok) begin
                pend_a <= {1'b0, d_a[AW-1:1]} + HALF;
                pend_u <= {r2, hold_r2};
                pend_l <= {r4, hold_r4};
            end

            if (w_en) wr_cnt <= wr_cnt + 1'b1;
            if (pair_err) pair_error_r <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= RUN;
                        write_select_r <= ~write_select_r;
                        busy_r         <= 1'b1;
                        rd_cnt         <= '0;
                        wr_cnt         <= '0;
                        pair_error_r   <= 1'b0;
                        hold_v         <= 1'b0;
                        pend_v         <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == N_WORDS - 1'b1) begin
                            state    <= FLUSH;
                            idle_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // A stage with pair errors never reaches the full count; the idle timeout ends it.
                    if (wr_cnt == N_WORDS || idle_cnt == IDLE_LIMIT) begin
                        state        <= DONE;
                        busy_r       <= 1'b0;
                        stage_done_r <= 1'b1;
                    end else if (d_v || pend_v) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    stage_done_r <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign write_select = write_select_r;
    assign busy         = busy_r;
    assign pair_error   = pair_error_r;

`ifdef NTT_WB_OUTREG_EN
    logic            w_en_q, stage_done_q;
    logic [AW-1:0]   w_addr_q;
    logic [2*DW-1:0] w_u_q, w_l_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_u_q        <= '0;
            w_l_q        <= '0;
            stage_done_q <= 1'b0;
        end else begin
            w_en_q       <= w_en;
            w_addr_q     <= w_addr;
            w_u_q        <= w_u;
            w_l_q        <= w_l;
            stage_done_q <= stage_done_r;
        end
    end

    assign upper_write_enable  = w_en_q;
    assign lower_write_enable  = w_en_q;
    assign upper_write_address = w_addr_q;
    assign lower_write_address = w_addr_q;
    assign upper_data_input    = w_u_q;
    assign lower_data_input    = w_l_q;
    assign stage_done          = stage_done_q;
`else
    assign upper_write_enable  = w_en;
    assign lower_write_enable  = w_en;
    assign upper_write_address = w_addr;
    assign lower_write_address = w_addr;
    assign upper_data_input    = w_u;
    assign lower_data_input    = w_l;
    assign stage_done          = stage_done_r;
`endif
endmodule
